// File: rtl/spi_target_shifter_pkg.sv
// Shared constants and helpers for the SPI target byte shifter.
// CRC16 is x^16+x^12+x^5+1, shifted MSB first, one bit per SCLK sample.
package spi_target_shifter_pkg;

   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam logic [7:0]  IDLE_BYTE_DEF = 8'hFF;

   // Controller-side speed encodings; the target only tolerates DIV6 and slower.
   typedef enum logic [1:0] {
      SPD_TURBO = 2'd0,
      SPD_DIV6  = 2'd1,
      SPD_DIV34 = 2'd2
   } spd_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // Number of clk cycles in one SCLK half period for a given speed.
   function automatic int spd_half_clks(input spd_t spd);
      case (spd)
         SPD_DIV6:  return 3;
         SPD_DIV34: return 17;
         default:   return 1;
      endcase
   endfunction

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
      logic fb;
      fb = bit_in ^ crc[15];
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/spi_target_shifter_if.sv
// Byte-stream side of the SPI target: transmit holding-register handshake,
// received-byte strobe and underrun strobe.
interface spi_target_shifter_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       underrun;

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output rx_data,
      output rx_valid,
      output underrun
   );

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  rx_data,
      input  rx_valid,
      input  underrun
   );

endinterface

// File: rtl/spi_target_shifter_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin, with single-cycle
// rise/fall pulses taken from the synchronized level and one extra history flop.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_target_shifter.sv
// SPI mode-0 target byte shifter, oversampled on clk: receives MOSI bytes,
// returns MISO bytes from a one-deep holding register, and runs a CRC16.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | cs_n high; SCLK edges ignored, MISO parked high, oe low
//   ST_ACTIVE | cs_n low; sample MOSI on SCLK rise, shift MISO on fall
module spi_target_shifter
   import spi_target_shifter_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cs_n,
   input  logic                       sclk,
   input  logic                       mosi,
   output logic                       miso,
   output logic                       miso_oe,
   spi_target_shifter_if.slave        stream,
   output logic                       selected,
   input  logic                       crc_reset,
   input  logic                       crc_source,
   output logic [15:0]                crc_out
);

   logic sclk_rise, sclk_fall, sclk_lvl_unused;
   logic cs_rise, cs_fall, cs_lvl_unused;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk  (clk),
      .rst  (rst),
      .d    (sclk),
      .q    (sclk_lvl_unused),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   // cs_n resets to its deselected level so reset release is not seen as a select.
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk  (clk),
      .rst  (rst),
      .d    (cs_n),
      .q    (cs_lvl_unused),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk  (clk),
      .rst  (rst),
      .d    (mosi),
      .q    (mosi_sync),
      .rise (mosi_rise_unused),
      .fall (mosi_fall_unused)
   );

   state_t      state_q, state_d;
   logic        do_select, do_load, do_sample, do_shift;
   logic [7:0]  tx_sr;
   logic [6:0]  rx_sr;
   logic [2:0]  bitcnt;
   logic        seen_rise;
   logic [7:0]  hold_data;
   logic        hold_full;
   logic        wr_accept;
   logic [7:0]  load_byte;
   logic [7:0]  rx_data_q;
   logic        rx_valid_q;
   logic        underrun_q;
   logic [15:0] crc;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // A CS rise in the same cycle as an SCLK edge ends the frame; the edge is dropped.
   always_comb begin
      state_d   = state_q;
      do_select = 1'b0;
      do_load   = 1'b0;
      do_sample = 1'b0;
      do_shift  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_ACTIVE;
               do_select = 1'b1;
               do_load   = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
            end else if (sclk_rise) begin
               do_sample = 1'b1;
            end else if (sclk_fall && seen_rise) begin
               if (bitcnt == 3'd0) do_load  = 1'b1;
               else                do_shift = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write wins over the load it coincides with: the load sees the old (empty) state.
   assign wr_accept = stream.tx_valid & ~hold_full;
   assign load_byte = hold_full ? hold_data : IDLE_BYTE;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_data <= 8'h00;
         hold_full <= 1'b0;
      end else if (wr_accept) begin
         hold_data <= stream.tx_data;
         hold_full <= 1'b1;
      end else if (do_load) begin
         hold_full <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_sr      <= 8'h00;
         rx_sr      <= 7'h00;
         bitcnt     <= 3'd0;
         seen_rise  <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         if (do_load) begin
            tx_sr      <= load_byte;
            underrun_q <= ~hold_full;
         end else if (do_shift) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
         end
         if (do_select) begin
            bitcnt    <= 3'd0;
            seen_rise <= 1'b0;
         end
         if (do_sample) begin
            rx_sr     <= {rx_sr[5:0], mosi_sync};
            bitcnt    <= bitcnt + 3'd1;
            seen_rise <= 1'b1;
            if (bitcnt == 3'd7) begin
               rx_data_q  <= {rx_sr, mosi_sync};
               rx_valid_q <= 1'b1;
            end
         end
      end
   end

   // The transmitted bit seen at a sample is the one currently driven on MISO.
   always_ff @(posedge clk) begin
      if (rst)            crc <= 16'h0000;
      else if (do_sample) crc <= crc16_step(crc, crc_source ? tx_sr[7] : mosi_sync);
      else if (crc_reset) crc <= 16'h0000;
   end

   assign selected        = (state_q == ST_ACTIVE);
   assign miso            = selected ? tx_sr[7] : 1'b1;
   assign miso_oe         = selected;
   assign crc_out         = crc;
   assign stream.tx_ready = ~hold_full;
   assign stream.rx_data  = rx_data_q;
   assign stream.rx_valid = rx_valid_q;
   assign stream.underrun = underrun_q;

endmodule

// File: tb/tb_spi_target_shifter.sv
// Directed plus randomized bench for spi_target_shifter, with a byte-level
// model of the holding register, underrun count and CRC.
module tb_spi_target_shifter;
   import spi_target_shifter_pkg::*;

   localparam int HALF = spd_half_clks(SPD_DIV6);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs_n = 1'b1;
   logic        sclk = 1'b0;
   logic        mosi = 1'b0;
   logic        miso, miso_oe, selected;
   logic        crc_reset = 1'b0;
   logic        crc_source = 1'b0;
   logic [15:0] crc_out;

   spi_target_shifter_if bus ();

   spi_target_shifter #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
      .clk        (clk),
      .rst        (rst),
      .cs_n       (cs_n),
      .sclk       (sclk),
      .mosi       (mosi),
      .miso       (miso),
      .miso_oe    (miso_oe),
      .stream     (bus),
      .selected   (selected),
      .crc_reset  (crc_reset),
      .crc_source (crc_source),
      .crc_out    (crc_out)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int rx_cnt = 0;
   int ur_cnt = 0;
   logic [7:0] rx_log[$];

   always @(negedge clk) begin
      if (bus.rx_valid === 1'b1) begin
         rx_cnt <= rx_cnt + 1;
         rx_log.push_back(bus.rx_data);
      end
      if (bus.underrun === 1'b1) ur_cnt <= ur_cnt + 1;
   end

   // Reference model: holding register, underrun tally and CRC16 over a bit stream.
   logic [7:0]  m_hold = 8'h00;
   bit          m_full = 1'b0;
   int          m_ur = 0;
   logic [15:0] m_crc = 16'h0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_load(output logic [7:0] b);
      if (m_full) begin
         b = m_hold;
         m_full = 1'b0;
      end else begin
         b = 8'hFF;
         m_ur++;
      end
   endtask

   task automatic crc_feed(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         if (m_crc[15] ^ b[i]) m_crc = (m_crc << 1) ^ 16'h1021;
         else                  m_crc = m_crc << 1;
      end
   endtask

   task automatic tx_write(input logic [7:0] d);
      check("tx_ready_before_write", 32'(bus.tx_ready), 32'(!m_full));
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      wait_clk(1);
      bus.tx_valid = 1'b0;
      if (!m_full) begin
         m_hold = d;
         m_full = 1'b1;
      end
   endtask

   task automatic spi_select();
      cs_n = 1'b0;
      wait_clk(8);
   endtask

   // SCLK is released low together with CS, so the final fall coincides with the CS rise.
   task automatic spi_deselect();
      wait_clk(2);
      cs_n = 1'b1;
      sclk = 1'b0;
      wait_clk(8);
   endtask

   // Clocks nbits MSB first; MISO is sampled at the end of each high phase. Leaves SCLK high.
   task automatic spi_bits(input logic [7:0] mo, input int nbits, input int wr_bit,
                           input logic [7:0] wr_d, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b0;
         mosi = mo[7-i];
         wait_clk(HALF);
         sclk = 1'b1;
         wait_clk(HALF);
         mi[7-i] = miso;
         if (i == wr_bit) tx_write(wr_d);
      end
   endtask

   function automatic logic [31:0] rx_at(input int idx);
      if (idx < rx_log.size()) return 32'(rx_log[idx]);
      return 32'hxxxx_xxxx;
   endfunction

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] mi, mo, eb, rx_prev, wd;
      logic [7:0] exp_q[$];
      int rx0, ur0, base, wr_bit;

      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      wait_clk(3);
      check("rst_miso",     32'(miso), 32'h1);
      check("rst_miso_oe",  32'(miso_oe), 32'h0);
      check("rst_tx_ready", 32'(bus.tx_ready), 32'h1);
      check("rst_rx_data",  32'(bus.rx_data), 32'h0);
      check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
      check("rst_underrun", 32'(bus.underrun), 32'h0);
      check("rst_selected", 32'(selected), 32'h0);
      check("rst_crc",      32'(crc_out), 32'h0);
      rst = 1'b0;
      wait_clk(4);

      // Loopback: preload A5, receive 3C.
      tx_write(8'hA5);
      rx0 = rx_cnt; base = rx_log.size();
      spi_select();
      model_load(eb);
      check("loop_tx_ready", 32'(bus.tx_ready), 32'h1);
      check("loop_selected", 32'(selected), 32'h1);
      check("loop_miso_oe",  32'(miso_oe), 32'h1);
      spi_bits(8'h3C, 8, -1, 8'h00, mi);
      check("loop_miso_byte", 32'(mi), 32'(eb));
      spi_deselect();
      check("loop_rx_count", 32'(rx_cnt - rx0), 32'd1);
      check("loop_rx_data",  rx_at(base), 32'h3C);
      check("loop_underrun", 32'(ur_cnt), 32'(m_ur));
      check("loop_idle_miso", 32'(miso), 32'h1);
      check("loop_idle_oe",   32'(miso_oe), 32'h0);

      // Underrun: three bytes with nothing written.
      rx0 = rx_cnt; ur0 = ur_cnt; base = rx_log.size(); exp_q.delete();
      spi_select();
      for (int j = 0; j < 3; j++) begin
         mo = 8'($urandom);
         model_load(eb);
         spi_bits(mo, 8, -1, 8'h00, mi);
         check("urun_miso", 32'(mi), 32'hFF);
         exp_q.push_back(mo);
      end
      spi_deselect();
      check("urun_pulses",   32'(ur_cnt - ur0), 32'd3);
      check("urun_rx_count", 32'(rx_cnt - rx0), 32'd3);
      for (int j = 0; j < 3; j++) check("urun_rx_data", rx_at(base + j), 32'(exp_q[j]));

      // Back-to-back: 01 before select, 02 written during bit 3.
      ur0 = ur_cnt;
      tx_write(8'h01);
      spi_select();
      model_load(eb);
      spi_bits(8'h11, 8, 3, 8'h02, mi);
      check("b2b_byte0", 32'(mi), 32'h01);
      model_load(eb);
      spi_bits(8'h22, 8, -1, 8'h00, mi);
      check("b2b_byte1", 32'(mi), 32'h02);
      spi_deselect();
      check("b2b_no_underrun", 32'(ur_cnt - ur0), 32'd0);

      // Write landing in the same cycle as the select load.
      ur0 = ur_cnt;
      cs_n = 1'b0;
      wait_clk(2);
      bus.tx_data  = 8'h5A;
      bus.tx_valid = 1'b1;
      wait_clk(1);
      bus.tx_valid = 1'b0;
      model_load(eb);
      m_hold = 8'h5A; m_full = 1'b1;
      wait_clk(5);
      check("same_cycle_captured", 32'(bus.tx_ready), 32'h0);
      spi_bits(8'h00, 8, -1, 8'h00, mi);
      check("same_cycle_byte0", 32'(mi), 32'hFF);
      model_load(eb);
      spi_bits(8'h00, 8, -1, 8'h00, mi);
      check("same_cycle_byte1", 32'(mi), 32'h5A);
      spi_deselect();
      check("same_cycle_underrun", 32'(ur_cnt - ur0), 32'd1);

      // Abort after 5 bits, then a clean byte on the next select.
      rx0 = rx_cnt; rx_prev = bus.rx_data;
      spi_select();
      model_load(eb);
      spi_bits(8'hFF, 5, -1, 8'h00, mi);
      spi_deselect();
      check("abort_no_rx", 32'(rx_cnt - rx0), 32'd0);
      check("abort_rx_held", 32'(bus.rx_data), 32'(rx_prev));
      base = rx_log.size();
      mo = 8'hC3;
      spi_select();
      model_load(eb);
      spi_bits(mo, 8, -1, 8'h00, mi);
      check("abort_next_miso", 32'(mi), 32'(eb));
      spi_deselect();
      check("abort_next_rx_count", 32'(rx_cnt - rx0), 32'd1);
      check("abort_next_rx_data", rx_at(base), 32'hC3);

      // SCLK activity while deselected must do nothing.
      rx0 = rx_cnt;
      for (int i = 0; i < 8; i++) begin
         mosi = 1'($urandom_range(1));
         wait_clk(HALF); sclk = 1'b1;
         wait_clk(HALF); sclk = 1'b0;
      end
      wait_clk(6);
      check("desel_no_rx", 32'(rx_cnt - rx0), 32'd0);
      check("desel_selected", 32'(selected), 32'h0);
      check("desel_underrun", 32'(ur_cnt), 32'(m_ur));

      // Randomized sessions against the model.
      for (int s = 0; s < 3; s++) begin
         crc_source = 1'($urandom_range(1));
         crc_reset = 1'b1; wait_clk(1); crc_reset = 1'b0; wait_clk(1);
         m_crc = 16'h0000;
         check("rand_crc_cleared", 32'(crc_out), 32'h0);
         if ($urandom_range(1) == 1) tx_write(8'($urandom));
         base = rx_log.size(); exp_q.delete();
         spi_select();
         for (int j = 0; j < 10; j++) begin
            if (j > 0 && $urandom_range(1) == 1) tx_write(8'($urandom));
            mo = 8'($urandom);
            wd = 8'($urandom);
            wr_bit = ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1;
            model_load(eb);
            spi_bits(mo, 8, wr_bit, wd, mi);
            check("rand_miso", 32'(mi), 32'(eb));
            crc_feed(crc_source ? eb : mo);
            exp_q.push_back(mo);
         end
         spi_deselect();
         check("rand_crc", 32'(crc_out), 32'(m_crc));
         check("rand_underrun", 32'(ur_cnt), 32'(m_ur));
         for (int j = 0; j < 10; j++) check("rand_rx_data", rx_at(base + j), 32'(exp_q[j]));
      end

      // CRC over 512 received FF bytes, then over 512 transmitted FF bytes.
      for (int src = 0; src < 2; src++) begin
         crc_source = 1'(src);
         crc_reset = 1'b1; wait_clk(1); crc_reset = 1'b0; wait_clk(1);
         rx0 = rx_cnt;
         spi_select();
         for (int j = 0; j < 512; j++) begin
            model_load(eb);
            spi_bits((src == 0) ? 8'hFF : 8'($urandom), 8, -1, 8'h00, mi);
         end
         spi_deselect();
         check(src == 0 ? "crc_rx_512xFF" : "crc_tx_512xFF", 32'(crc_out), 32'h7FA1);
         check("crc_rx_count", 32'(rx_cnt - rx0), 32'd512);
      end
      check("crc_underrun_total", 32'(ur_cnt), 32'(m_ur));

      // Synchronous reset in the middle of a byte.
      crc_source = 1'b0;
      tx_write(8'h77);
      spi_select();
      model_load(eb);
      spi_bits(8'($urandom), 4, 1, 8'h88, mi);
      check("srst_pre_tx_ready", 32'(bus.tx_ready), 32'h0);
      rx0 = rx_cnt; ur0 = ur_cnt;
      rst = 1'b1;
      wait_clk(1);
      check("srst_miso_oe",  32'(miso_oe), 32'h0);
      check("srst_crc",      32'(crc_out), 32'h0);
      check("srst_tx_ready", 32'(bus.tx_ready), 32'h1);
      check("srst_selected", 32'(selected), 32'h0);
      check("srst_miso",     32'(miso), 32'h1);
      check("srst_rx_data",  32'(bus.rx_data), 32'h0);
      cs_n = 1'b1; sclk = 1'b0;
      wait_clk(1);
      rst = 1'b0;
      m_full = 1'b0;
      wait_clk(8);
      check("srst_no_rx", 32'(rx_cnt - rx0), 32'd0);
      check("srst_no_underrun", 32'(ur_cnt - ur0), 32'd0);
      check("srst_stays_idle", 32'(selected), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
